rv32i_instr_encoder: RTL and testbench
======================================

// Module: rv32i_instr_encoder
// PURPOSE
//  Encodes RV32I instruction fields (opcode, funct3/7, rs1, rs2, rd, immediate) into 32-bit words.
//  It is the inverse of the instruction decoder. Each word passes through a FIFO with a valid/ready interface.
//  Sources: boot/self-test sequencer writing programs to instruction memory; round-trip bench against the decoder.
//  Unencodable requests are replaced by NOP and flagged.
// PARAMETERS
//  FIFO_DEPTH  4   output FIFO entries; power of 2, >= 2
// PORTS
//  clk        in   1   clock, rising edge
//  rst_n      in   1   asynchronous active-low reset
//  flush      in   1   synchronous FIFO clear
//  in_valid   in   1   request valid
//  in_ready   out  1   request accepted when in_valid & in_ready
//  in_opcode  in   7   instr[6:0]
//  in_funct3  in   3   instr[14:12]
//  in_funct7  in   7   R-type / shift-immediate funct7
//  in_rs1     in   5   source register 1
//  in_rs2     in   5   source register 2
//  in_rd      in   5   destination register
//  in_imm     in   32  full signed byte-offset / value immediate (pre-split form)
//  out_valid  out  1   FIFO head valid
//  out_ready  in   1   consumer pops head when out_valid & out_ready
//  out_instr  out  32  encoded word at head
//  out_err    out  1   head word was substituted NOP
//  err_cnt    out  16  accepted error requests, saturating
// BEHAVIOUR
//  Reset: FIFO pointers and occupancy 0, out_valid=0, err_cnt=0.
//  out_instr=0 and out_err=0 whenever out_valid=0; both are gated from the FIFO head.
//  in_ready = !full & !flush. A push is blocked when full, even if a pop happens in the same cycle.
//  Encoding is combinational from the inputs; the word is written on the accept edge.
//  Latency: a word accepted at edge k is visible on out_* after edge k.
//  Push and pop in the same cycle (not full, not empty): occupancy unchanged, order preserved.
//  Pointers are log2(FIFO_DEPTH) bits, wrap naturally, with a separate occupancy counter.
//  flush: pointers and occupancy go to 0 at the next edge; input is not accepted; err_cnt keeps its value.
//  Reset mid-transfer: all queued words are lost; out_valid=0 immediately (async).
//  Encoding by opcode; any failed check -> word 32'h00000013, err=1:
//   0110011 R : {f7,rs2,rs1,f3,rd,op}. Error if f7 is not 0000000, or f7=0100000 with f3 not 000/101.
//   0010011 f3=001/101 shift : {f7,imm[4:0],rs1,f3,rd,op}. Error if imm[31:5]!=0.
//           Also error if f7 is not 0000000, or f7=0100000 with f3!=101.
//   0010011 other f3 / 0000011 / 1100111 I : {imm[11:0],rs1,f3,rd,op}.
//           Error if imm is not the sign-extension of imm[11:0].
//           LOAD: f3 must be in {000,001,010,100,101}. JALR: f3 must be 000.
//   0100011 S : {imm[11:5],rs2,rs1,f3,imm[4:0],op}. 12-bit signed range; f3 in {000,001,010}.
//   1100011 B : {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}.
//           Error if imm[0]=1, imm is outside the 13-bit signed range, or f3 is 010/011.
//   0110111/0010111 U : {imm[31:12],rd,op}. Error if imm[11:0]!=0.
//   1101111 J : {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
//           Error if imm[0]=1 or imm is outside the 21-bit signed range.
//   Any other opcode: error.
//  Unused fields are ignored, e.g. rs2 for I-type.
//  err_cnt increments once per accepted request with err=1 and saturates at 16'hFFFF.
// TESTING
//  ADDI: op=0010011 f3=000 rd=1 rs1=0 imm=5 -> out_instr=32'h00500093, out_err=0, one cycle after accept.
//  BEQ: rs1=1 rs2=2 imm=32'hFFFFFFF8 -> 32'hFE208CE3. Same with imm=3 -> 32'h00000013, out_err=1, err_cnt=1.
//  JAL: rd=1 imm=32'h800 -> 32'h001000EF. LUI: rd=5 imm=32'h12345000 -> 32'h123452B7.
//   LUI imm=32'h12345001 -> NOP, err.
//  FIFO: out_ready=0, present 5 valid requests -> in_ready drops after 4 accepts.
//   Then out_ready=1 with continuous push -> words drain in order, no loss or duplication across wrap.
//  flush with 3 queued words -> out_valid=0 next cycle, err_cnt unchanged.
//   Assert rst_n=0 mid-stream -> out_valid=0 at once; err_cnt=0.
//  Round-trip: random legal fields -> encoder -> decoder. Decoder fields and imm_ext must match the inputs.
//   Shift-immediate compares zero-extended imm[4:0].

Source files
------------

// File: rtl/rv32i_instr_encoder.sv
// RV32I instruction encoder: packs instruction fields into a 32-bit word,
// replaces unencodable requests with a flagged NOP, and queues the result
// in a small valid/ready FIFO.
module rv32i_instr_encoder #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic [15:0] err_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = FIFO_DEPTH;
  localparam logic [31:0]   NOP_WORD = 32'h0000_0013;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [31:0] raw_word;
  logic        bad;
  logic [31:0] enc_word;
  logic        enc_err;
  logic        fits_12;
  logic        fits_13;
  logic        fits_21;
  logic        f7_zero;
  logic        f7_alt;
  logic [31:0] i_word;

  // Immediate range tests: upper bits must all equal the sign bit of the field.
  assign fits_12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign fits_13 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
  assign fits_21 = (&in_imm[31:20]) | ~(|in_imm[31:20]);
  assign f7_zero = (in_funct7 == 7'b0000000);
  assign f7_alt  = (in_funct7 == 7'b0100000);
  assign i_word  = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};

  // Format selection and legality checks, decided by opcode.
  always_comb begin
    raw_word = NOP_WORD;
    bad      = 1'b1;
    case (in_opcode)
      OP_R: begin
        raw_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
        bad      = !(f7_zero || (f7_alt && (in_funct3 == 3'b000 || in_funct3 == 3'b101)));
      end
      OP_IMM: begin
        if (in_funct3 == 3'b001 || in_funct3 == 3'b101) begin
          raw_word = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
          bad      = (|in_imm[31:5]) || !(f7_zero || (f7_alt && in_funct3 == 3'b101));
        end else begin
          raw_word = i_word;
          bad      = !fits_12;
        end
      end
      OP_LOAD: begin
        raw_word = i_word;
        bad      = !fits_12 || in_funct3 == 3'b011 || in_funct3 == 3'b110 || in_funct3 == 3'b111;
      end
      OP_JALR: begin
        raw_word = i_word;
        bad      = !fits_12 || in_funct3 != 3'b000;
      end
      OP_STORE: begin
        raw_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        bad      = !fits_12 || in_funct3 > 3'b010;
      end
      OP_BRANCH: begin
        raw_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                    in_imm[4:1], in_imm[11], in_opcode};
        bad      = in_imm[0] || !fits_13 || in_funct3 == 3'b010 || in_funct3 == 3'b011;
      end
      OP_LUI, OP_AUIPC: begin
        raw_word = {in_imm[31:12], in_rd, in_opcode};
        bad      = |in_imm[11:0];
      end
      OP_JAL: begin
        raw_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        bad      = in_imm[0] || !fits_21;
      end
      default: begin
        raw_word = NOP_WORD;
        bad      = 1'b1;
      end
    endcase
  end

  assign enc_word = bad ? NOP_WORD : raw_word;
  assign enc_err  = bad;

  // FIFO storage and control
  logic [32:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          full;
  logic          push;
  logic          pop;
  logic [32:0]   head;

  assign full      = (count_reg == CNT_FULL);
  assign in_ready  = !full && !flush;
  assign push      = in_valid && in_ready;
  assign out_valid = (count_reg != '0);
  assign pop       = out_valid && out_ready && !flush;
  assign head      = mem[rd_ptr_reg];
  assign out_instr = out_valid ? head[31:0] : 32'h0;
  assign out_err   = out_valid & head[32];

  // Storage array is written on accept; no reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {enc_err, enc_word};
    end
  end

  // Pointers and occupancy; flush empties the queue without touching storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      if (push && !pop)      count_reg <= count_reg + CNT_ONE;
      else if (!push && pop) count_reg <= count_reg - CNT_ONE;
    end
  end

  // Saturating count of accepted requests that had to be replaced by NOP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= 16'h0;
    end else if (push && enc_err && err_cnt != 16'hFFFF) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// Scoreboard bench for rv32i_instr_encoder: directed encodings, FIFO
// backpressure/flush/reset, and random legal round-trips through a decoder.
module tb_rv32i_instr_encoder;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [4:0]  in_rd;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [15:0] err_cnt;

  rv32i_instr_encoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    bit          exact;
    logic [31:0] word;
    logic        err;
    logic [63:0] key;
  } req_t;

  req_t        sb[$];
  req_t        cur;
  req_t        mon_e;
  bit          acc_now;
  logic [15:0] exp_cnt;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] sx12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction
  function automatic logic [31:0] sx13(input logic [12:0] v);
    return {{19{v[12]}}, v};
  endfunction
  function automatic logic [31:0] sx21(input logic [20:0] v);
    return {{11{v[20]}}, v};
  endfunction

  // Canonical field set for a request: fields the format does not carry are zeroed.
  function automatic logic [63:0] canon(input logic [6:0] op, input logic [2:0] f3,
      input logic [6:0] f7, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [4:0] rd, input logic [31:0] imm);
    case (op)
      7'b0110011: return {op, f3, f7, rs1, rs2, rd, 32'h0};
      7'b0010011:
        if (f3 == 3'b001 || f3 == 3'b101) return {op, f3, f7, rs1, 5'h0, rd, {27'h0, imm[4:0]}};
        else return {op, f3, 7'h0, rs1, 5'h0, rd, imm};
      7'b0000011, 7'b1100111: return {op, f3, 7'h0, rs1, 5'h0, rd, imm};
      7'b0100011, 7'b1100011: return {op, f3, 7'h0, rs1, rs2, 5'h0, imm};
      default: return {op, 3'h0, 7'h0, 5'h0, 5'h0, rd, imm};
    endcase
  endfunction

  // Reference decoder producing the same canonical field set from a word.
  function automatic logic [63:0] decode(input logic [31:0] i);
    logic [6:0] op;
    op = i[6:0];
    case (op)
      7'b0110011: return {op, i[14:12], i[31:25], i[19:15], i[24:20], i[11:7], 32'h0};
      7'b0010011:
        if (i[14:12] == 3'b001 || i[14:12] == 3'b101)
          return {op, i[14:12], i[31:25], i[19:15], 5'h0, i[11:7], {27'h0, i[24:20]}};
        else return {op, i[14:12], 7'h0, i[19:15], 5'h0, i[11:7], sx12(i[31:20])};
      7'b0000011, 7'b1100111:
        return {op, i[14:12], 7'h0, i[19:15], 5'h0, i[11:7], sx12(i[31:20])};
      7'b0100011:
        return {op, i[14:12], 7'h0, i[19:15], i[24:20], 5'h0, sx12({i[31:25], i[11:7]})};
      7'b1100011:
        return {op, i[14:12], 7'h0, i[19:15], i[24:20], 5'h0,
                sx13({i[31], i[7], i[30:25], i[11:8], 1'b0})};
      7'b0110111, 7'b0010111:
        return {op, 3'h0, 7'h0, 5'h0, 5'h0, i[11:7], {i[31:12], 12'h0}};
      7'b1101111:
        return {op, 3'h0, 7'h0, 5'h0, 5'h0, i[11:7],
                sx21({i[31], i[19:12], i[20], i[30:21], 1'b0})};
      default: return 64'hDEAD_DEAD_DEAD_DEAD;
    endcase
  endfunction

  function automatic req_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
      input logic [31:0] imm, input logic [31:0] word, input logic err);
    req_t r;
    r.op = op; r.f3 = f3; r.f7 = f7; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.imm = imm;
    r.exact = 1'b1; r.word = word; r.err = err; r.key = '0;
    return r;
  endfunction

  function automatic req_t rand_legal();
    req_t r;
    int   k;
    r.rs1 = 5'($urandom); r.rs2 = 5'($urandom); r.rd = 5'($urandom);
    r.f3 = 3'($urandom); r.f7 = 7'($urandom); r.imm = $urandom;
    k = $urandom_range(0, 8);
    case (k)
      0: begin
        r.op = 7'b0110011;
        r.f7 = ((r.f3 == 3'd0 || r.f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      end
      1: begin
        r.op = 7'b0010011;
        r.f3 = ($urandom_range(0, 1) == 1) ? 3'd1 : 3'd5;
        r.f7 = (r.f3 == 3'd5 && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        r.imm = 32'($urandom_range(0, 31));
      end
      2: begin
        r.op = 7'b0010011;
        while (r.f3 == 3'd1 || r.f3 == 3'd5) r.f3 = 3'($urandom);
        r.imm = sx12(12'($urandom));
      end
      3: begin
        r.op = 7'b0000011;
        while (r.f3 == 3'd3 || r.f3 >= 3'd6) r.f3 = 3'($urandom);
        r.imm = sx12(12'($urandom));
      end
      4: begin
        r.op = 7'b1100111; r.f3 = 3'd0; r.imm = sx12(12'($urandom));
      end
      5: begin
        r.op = 7'b0100011; r.f3 = 3'($urandom_range(0, 2)); r.imm = sx12(12'($urandom));
      end
      6: begin
        r.op = 7'b1100011;
        while (r.f3 == 3'd2 || r.f3 == 3'd3) r.f3 = 3'($urandom);
        r.imm = sx13(13'($urandom)) & 32'hFFFF_FFFE;
      end
      7: begin
        r.op = ($urandom_range(0, 1) == 1) ? 7'b0110111 : 7'b0010111;
        r.imm = $urandom & 32'hFFFF_F000;
      end
      default: begin
        r.op = 7'b1101111; r.imm = sx21(21'($urandom)) & 32'hFFFF_FFFE;
      end
    endcase
    r.exact = 1'b0; r.word = '0; r.err = 1'b0;
    r.key = canon(r.op, r.f3, r.f7, r.rs1, r.rs2, r.rd, r.imm);
    return r;
  endfunction

  // Monitor: mid-cycle, check handshake/status against the model, then
  // apply the pop and push the coming edge will perform.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      exp_cnt = 16'h0;
      acc_now = 1'b0;
      check("rst_hold_valid", out_valid, 1'b0);
      check("rst_hold_cnt", err_cnt, 16'h0);
    end else begin
      check("in_ready", in_ready, (sb.size() < DEPTH) && !flush);
      check("out_valid", out_valid, sb.size() != 0);
      if (sb.size() == 0) check("idle_gate", {out_err, out_instr}, 33'h0);
      check("err_cnt", err_cnt, exp_cnt);
      if (flush) begin
        sb.delete();
        acc_now = 1'b0;
      end else begin
        if (out_valid && out_ready && sb.size() != 0) begin
          mon_e = sb.pop_front();
          if (mon_e.exact) begin
            check("word", {out_err, out_instr}, {mon_e.err, mon_e.word});
          end else begin
            check("rt_err", out_err, 1'b0);
            check("rt_fields", decode(out_instr), mon_e.key);
          end
        end
        acc_now = in_valid && in_ready;
        if (acc_now) begin
          sb.push_back(cur);
          if (cur.err && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        end
      end
    end
  end

  task automatic drive(input req_t r);
    int waits;
    waits = 0;
    cur = r;
    in_opcode = r.op; in_funct3 = r.f3; in_funct7 = r.f7;
    in_rs1 = r.rs1; in_rs2 = r.rs2; in_rd = r.rd; in_imm = r.imm;
    in_valid = 1'b1;
    forever begin
      @(negedge clk); #1;
      if (acc_now) break;
      waits++;
      if (waits > 200) begin
        check("accept_timeout", 1'b0, 1'b1);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_done", sb.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] cnt_before;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_opcode = '0; in_funct3 = '0; in_funct7 = '0;
    in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_imm = '0;
    cur = mk(7'h0, 3'h0, 7'h0, 5'h0, 5'h0, 5'h0, 32'h0, 32'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_err_cnt", err_cnt, 16'h0);
    check("reset_out_gate", {out_err, out_instr}, 33'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ADDI latency: visible right after the accepting edge
    drive(mk(7'b0010011, 3'd0, 7'h0, 5'd0, 5'd0, 5'd1, 32'd5, 32'h0050_0093, 1'b0));
    check("addi_latency_valid", out_valid, 1'b1);
    check("addi_word", {out_err, out_instr}, {1'b0, 32'h0050_0093});
    wait_drain();

    drive(mk(7'b1100011, 3'd0, 7'h0, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFF8, 32'hFE20_8CE3, 1'b0));
    drive(mk(7'b1100011, 3'd0, 7'h0, 5'd1, 5'd2, 5'd0, 32'd3, 32'h0000_0013, 1'b1));
    check("beq_bad_err_cnt", err_cnt, 16'd1);
    drive(mk(7'b1101111, 3'd0, 7'h0, 5'd0, 5'd0, 5'd1, 32'h800, 32'h0010_00EF, 1'b0));
    drive(mk(7'b0110111, 3'd0, 7'h0, 5'd0, 5'd0, 5'd5, 32'h1234_5000, 32'h1234_52B7, 1'b0));
    drive(mk(7'b0110111, 3'd0, 7'h0, 5'd0, 5'd0, 5'd5, 32'h1234_5001, 32'h0000_0013, 1'b1));
    drive(mk(7'b0010011, 3'd5, 7'h20, 5'd2, 5'd0, 5'd1, 32'd3, 32'h4031_5093, 1'b0));
    drive(mk(7'b0010011, 3'd1, 7'h00, 5'd2, 5'd0, 5'd1, 32'd32, 32'h0000_0013, 1'b1));
    drive(mk(7'b0010011, 3'd1, 7'h20, 5'd2, 5'd0, 5'd1, 32'd3, 32'h0000_0013, 1'b1));
    drive(mk(7'b0010011, 3'd0, 7'h0, 5'd0, 5'd0, 5'd1, 32'd2047, 32'h7FF0_0093, 1'b0));
    drive(mk(7'b0010011, 3'd0, 7'h0, 5'd0, 5'd0, 5'd1, 32'd2048, 32'h0000_0013, 1'b1));
    drive(mk(7'b0110011, 3'd0, 7'h20, 5'd1, 5'd2, 5'd3, 32'h0, 32'h4020_81B3, 1'b0));
    drive(mk(7'b0110011, 3'd1, 7'h20, 5'd1, 5'd2, 5'd3, 32'h0, 32'h0000_0013, 1'b1));
    drive(mk(7'b0100011, 3'd3, 7'h0, 5'd1, 5'd2, 5'd0, 32'd4, 32'h0000_0013, 1'b1));
    drive(mk(7'b0000000, 3'd0, 7'h0, 5'd1, 5'd2, 5'd3, 32'd0, 32'h0000_0013, 1'b1));
    drive(mk(7'b1100011, 3'd0, 7'h0, 5'd1, 5'd2, 5'd0, 32'hFFFF_F000, 32'h8020_8063, 1'b0));
    drive(mk(7'b1100011, 3'd0, 7'h0, 5'd1, 5'd2, 5'd0, 32'd4096, 32'h0000_0013, 1'b1));
    drive(mk(7'b1100111, 3'd1, 7'h0, 5'd1, 5'd0, 5'd1, 32'd0, 32'h0000_0013, 1'b1));
    wait_drain();

    // Backpressure: five requests, consumer stalled; the fifth must wait
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) drive(rand_legal());
      end
      begin
        repeat (8) @(posedge clk);
        #1;
        check("full_blocks_in_ready", in_ready, 1'b0);
        out_ready = 1'b1;
      end
    join
    for (int i = 0; i < 12; i++) drive(rand_legal());
    wait_drain();

    // Random round-trip with a randomly stalling consumer
    fork
      begin
        for (int i = 0; i < 40; i++) drive(rand_legal());
      end
      begin
        for (int i = 0; i < 60; i++) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Flush with three queued words, one of them an error
    out_ready = 1'b0;
    drive(rand_legal());
    drive(mk(7'b0110111, 3'd0, 7'h0, 5'd0, 5'd0, 5'd5, 32'h0000_0001, 32'h0000_0013, 1'b1));
    drive(rand_legal());
    cnt_before = exp_cnt;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_err_cnt_kept", err_cnt, cnt_before);
    drive(mk(7'b0010011, 3'd0, 7'h0, 5'd0, 5'd0, 5'd1, 32'd5, 32'h0050_0093, 1'b0));
    wait_drain();

    // Asynchronous reset in the middle of a cycle with words queued
    out_ready = 1'b0;
    drive(rand_legal());
    drive(rand_legal());
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 1'b0);
    check("async_rst_err_cnt", err_cnt, 16'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_out_valid", out_valid, 1'b0);
    drive(mk(7'b1101111, 3'd0, 7'h0, 5'd0, 5'd0, 5'd1, 32'h800, 32'h0010_00EF, 1'b0));
    wait_drain();
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
